// File: rtl/jump_target_predictor_pkg.sv
// -----------------------------------------------------------------------------
// jtp_pkg
// Shared definitions for the jump target predictor:
//   - jump_type_e : encodings carried on i_type
//   - chkpt_t     : {tos, count} return-stack checkpoint for the default
//                   eight-entry stack (packed layout matches o_chkpt)
// -----------------------------------------------------------------------------
package jtp_pkg;

    typedef enum logic [2:0] {
        JAL  = 3'd1,
        BR   = 3'd2,
        JALR = 3'd3,
        CALL = 3'd4,
        RET  = 3'd5
    } jump_type_e;

    localparam int unsigned DEF_RAS_DEPTH = 8;
    localparam int unsigned DEF_PTR_W     = $clog2(DEF_RAS_DEPTH);

    // tos sits in the upper bits, count (0..depth) in the lower bits
    typedef struct packed {
        logic [DEF_PTR_W-1:0] tos;
        logic [DEF_PTR_W:0]   count;
    } chkpt_t;

endpackage

// File: rtl/jump_target_predictor_if.sv
// -----------------------------------------------------------------------------
// jump_target_predictor_if
// Request / response / redirect / training bundle of the predictor.
//   slave  : predictor side (i_* in, o_* out)
//   master : fetch/backend side (i_* out, o_* in)
// -----------------------------------------------------------------------------
interface jump_target_predictor_if #(
    parameter int XLEN  = 32,
    parameter int CHK_W = 7
);
    logic             i_valid;
    logic [2:0]       i_type;
    logic [XLEN-1:0]  i_pc;
    logic [XLEN-1:0]  i_jaddr;
    logic [XLEN-1:0]  i_retAddr;
    logic             o_valid;
    logic [XLEN-1:0]  o_nextPc;
    logic             o_hit;
    logic [CHK_W-1:0] o_chkpt;
    logic             i_redirect;
    logic [XLEN-1:0]  i_redirectPc;
    logic [CHK_W-1:0] i_redirectChkpt;
    logic             i_updValid;
    logic [XLEN-1:0]  i_updPc;
    logic [XLEN-1:0]  i_updTarget;

    modport slave (
        input  i_valid, i_type, i_pc, i_jaddr, i_retAddr,
        input  i_redirect, i_redirectPc, i_redirectChkpt,
        input  i_updValid, i_updPc, i_updTarget,
        output o_valid, o_nextPc, o_hit, o_chkpt
    );

    modport master (
        output i_valid, i_type, i_pc, i_jaddr, i_retAddr,
        output i_redirect, i_redirectPc, i_redirectChkpt,
        output i_updValid, i_updPc, i_updTarget,
        input  o_valid, o_nextPc, o_hit, o_chkpt
    );
endinterface

// File: rtl/jtp_ras.sv
// -----------------------------------------------------------------------------
// jtp_ras
// Circular return-address stack.
//   clk, rst          : clock, async active-low reset (clears tos/count)
//   i_push/i_pop      : push i_push_data / pop top (push wins if both)
//   i_restore         : load {tos,count} from i_restore_chkpt (highest priority)
//   o_top             : entry at tos
//   o_empty           : count == 0
//   o_chkpt           : current {tos, count}
// -----------------------------------------------------------------------------
module jtp_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 8,
    parameter int PTR_W     = $clog2(RAS_DEPTH),
    parameter int CHK_W     = 2*PTR_W+1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_restore,
    input  logic [CHK_W-1:0] i_restore_chkpt,
    input  logic [XLEN-1:0]  i_push_data,
    output logic [XLEN-1:0]  o_top,
    output logic             o_empty,
    output logic [CHK_W-1:0] o_chkpt
);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(RAS_DEPTH);

    logic [PTR_W-1:0] r_tos;
    logic [PTR_W:0]   r_count;
    logic [XLEN-1:0]  r_stack [RAS_DEPTH];
    logic [PTR_W-1:0] w_tos_inc;

    // power-of-two depth, so pointer arithmetic wraps for free
    assign w_tos_inc = r_tos + PTR_W'(1);

    // Stack pointer and occupancy; a full push overwrites the oldest slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tos   <= '0;
            r_count <= '0;
        end else if (i_restore) begin
            {r_tos, r_count} <= i_restore_chkpt;
        end else if (i_push) begin
            r_tos   <= w_tos_inc;
            r_count <= (r_count == FULL) ? FULL : r_count + (PTR_W+1)'(1);
        end else if (i_pop) begin
            r_tos   <= r_tos - PTR_W'(1);
            r_count <= r_count - (PTR_W+1)'(1);
        end else begin
            r_tos   <= r_tos;
            r_count <= r_count;
        end
    end

    // Entry storage; contents are not reset and not restored on redirect
    always_ff @(posedge clk) begin
        if (i_push && !i_restore) begin
            r_stack[w_tos_inc] <= i_push_data;
        end
    end

    assign o_top   = r_stack[r_tos];
    assign o_empty = (r_count == '0);
    assign o_chkpt = {r_tos, r_count};
endmodule

// File: rtl/jump_target_predictor.sv
// -----------------------------------------------------------------------------
// jump_target_predictor
// One-cycle next-PC predictor for the first taken jump of a fetch block.
//   clk, rst : clock, async active-low reset
//   bus      : jump_target_predictor_if.slave
//              request  i_valid/i_type/i_pc/i_jaddr/i_retAddr
//              response o_valid/o_nextPc/o_hit/o_chkpt (all registered)
//              redirect i_redirect/i_redirectPc/i_redirectChkpt
//              training i_updValid/i_updPc/i_updTarget (JALR BTB)
// -----------------------------------------------------------------------------
module jump_target_predictor
    import jtp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int RAS_DEPTH   = 8,
    parameter int BTB_ENTRIES = 8,
    parameter int TAG_BITS    = 8,
    parameter int CHK_W       = 2*$clog2(RAS_DEPTH)+1
)(
    input  logic clk,
    input  logic rst,
    jump_target_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);

    logic [BTB_ENTRIES-1:0] r_btb_valid;
    logic [TAG_BITS-1:0]    r_btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        r_btb_target [BTB_ENTRIES];

    logic                r_valid;
    logic [XLEN-1:0]     r_next_pc;
    logic                r_hit;
    logic [CHK_W-1:0]    r_chkpt;

    logic [IDX_W-1:0]    w_lk_idx, w_upd_idx;
    logic [TAG_BITS-1:0] w_lk_tag, w_upd_tag;
    logic                w_btb_hit;
    logic [XLEN-1:0]     w_pc_plus4;
    logic                w_accept;
    logic                w_push, w_pop, w_hit;
    logic [XLEN-1:0]     w_next_pc;
    logic [XLEN-1:0]     w_ras_top;
    logic                w_ras_empty;
    logic [CHK_W-1:0]    w_ras_chkpt;
    logic                w_unused_upd;

    assign w_lk_idx   = bus.i_pc[2 +: IDX_W];
    assign w_lk_tag   = bus.i_pc[2+IDX_W +: TAG_BITS];
    assign w_upd_idx  = bus.i_updPc[2 +: IDX_W];
    assign w_upd_tag  = bus.i_updPc[2+IDX_W +: TAG_BITS];
    assign w_pc_plus4 = bus.i_pc + XLEN'(3'd4);
    assign w_accept   = bus.i_valid & ~bus.i_redirect;
    // registered BTB read: a same-cycle write is seen only from the next cycle
    assign w_btb_hit  = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
    assign w_unused_upd = ^bus.i_updPc;

    jtp_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH),
        .CHK_W     (CHK_W)
    ) u_ras (
        .clk             (clk),
        .rst             (rst),
        .i_push          (w_push),
        .i_pop           (w_pop),
        .i_restore       (bus.i_redirect),
        .i_restore_chkpt (bus.i_redirectChkpt),
        .i_push_data     (bus.i_retAddr),
        .o_top           (w_ras_top),
        .o_empty         (w_ras_empty),
        .o_chkpt         (w_ras_chkpt)
    );

    // BTB valid bits, cleared by reset; training is independent of redirect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btb_valid <= '0;
        end else if (bus.i_updValid) begin
            r_btb_valid[w_upd_idx] <= 1'b1;
        end else begin
            r_btb_valid <= r_btb_valid;
        end
    end

    // BTB tag/target payload
    always_ff @(posedge clk) begin
        if (bus.i_updValid) begin
            r_btb_tag[w_upd_idx]    <= w_upd_tag;
            r_btb_target[w_upd_idx] <= bus.i_updTarget;
        end
    end

    // Target selection and stack control for an accepted request
    always_comb begin
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_hit     = 1'b1;
        w_next_pc = bus.i_jaddr;
        if (w_accept) begin
            case (jump_type_e'(bus.i_type))
                CALL: begin
                    w_push = 1'b1;
                end
                RET: begin
                    if (!w_ras_empty) begin
                        w_next_pc = w_ras_top;
                        w_pop     = 1'b1;
                    end else begin
                        w_next_pc = w_pc_plus4;
                        w_hit     = 1'b0;
                    end
                end
                JALR: begin
                    if (w_btb_hit) begin
                        w_next_pc = r_btb_target[w_lk_idx];
                    end else begin
                        w_next_pc = w_pc_plus4;
                        w_hit     = 1'b0;
                    end
                end
                default: begin
                    w_next_pc = bus.i_jaddr;
                end
            endcase
        end else begin
            w_push = 1'b0;
            w_pop  = 1'b0;
        end
    end

    // Registered response; redirect overrides and drops the request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_next_pc <= '0;
            r_hit     <= 1'b0;
            r_chkpt   <= '0;
        end else if (bus.i_redirect) begin
            r_valid   <= 1'b1;
            r_next_pc <= bus.i_redirectPc;
            r_hit     <= 1'b1;
            r_chkpt   <= bus.i_redirectChkpt;
        end else if (bus.i_valid) begin
            r_valid   <= 1'b1;
            r_next_pc <= w_next_pc;
            r_hit     <= w_hit;
            r_chkpt   <= w_ras_chkpt;
        end else begin
            r_valid   <= 1'b0;
            r_next_pc <= r_next_pc;
            r_hit     <= r_hit;
            r_chkpt   <= r_chkpt;
        end
    end

    assign bus.o_valid  = r_valid;
    assign bus.o_nextPc = r_next_pc;
    assign bus.o_hit    = r_hit;
    assign bus.o_chkpt  = r_chkpt;
endmodule

// File: tb/tb_jump_target_predictor.sv
// -----------------------------------------------------------------------------
// tb_jump_target_predictor
// Directed scenarios plus a randomized run against a behavioural model of the
// return stack (array + tos/count integers) and the JALR BTB (arrays by index).
// -----------------------------------------------------------------------------
module tb_jump_target_predictor;
    import jtp_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    jump_target_predictor_if #(.XLEN(32), .CHK_W(7)) bus();

    jump_target_predictor #(
        .XLEN(32), .RAS_DEPTH(8), .BTB_ENTRIES(8), .TAG_BITS(8), .CHK_W(7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model state
    logic [31:0] m_stack [8];
    int          m_tos;
    int          m_count;
    logic        m_bv   [8];
    logic [7:0]  m_btag [8];
    logic [31:0] m_btgt [8];

    // expectation of the most recent step
    logic        e_v;
    logic        e_hit;
    logic        e_rd;
    logic [31:0] e_pc;
    logic [6:0]  e_chk;

    task automatic model_reset();
        m_tos   = 0;
        m_count = 0;
        for (int i = 0; i < 8; i++) m_bv[i] = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.i_valid = 1'b0; bus.i_type = 3'd0; bus.i_pc = 32'h0;
        bus.i_jaddr = 32'h0; bus.i_retAddr = 32'h0;
        bus.i_redirect = 1'b0; bus.i_redirectPc = 32'h0; bus.i_redirectChkpt = 7'h0;
        bus.i_updValid = 1'b0; bus.i_updPc = 32'h0; bus.i_updTarget = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Drive one cycle, predict via the model, advance to 1 time unit past the edge
    task automatic step(input logic v, input logic [2:0] t, input logic [31:0] pc,
                        input logic [31:0] ja, input logic [31:0] ra,
                        input logic rd, input logic [31:0] rdpc, input logic [6:0] rdchk,
                        input logic uv, input logic [31:0] upc, input logic [31:0] ut);
        int idx;
        bus.i_valid = v; bus.i_type = t; bus.i_pc = pc; bus.i_jaddr = ja; bus.i_retAddr = ra;
        bus.i_redirect = rd; bus.i_redirectPc = rdpc; bus.i_redirectChkpt = rdchk;
        bus.i_updValid = uv; bus.i_updPc = upc; bus.i_updTarget = ut;
        e_rd = rd;
        if (rd) begin
            e_v = 1'b1; e_pc = rdpc; e_hit = 1'b1; e_chk = rdchk;
            m_tos   = int'(rdchk[6:4]);
            m_count = int'(rdchk[3:0]);
        end else if (v) begin
            e_v   = 1'b1;
            e_chk = {m_tos[2:0], m_count[3:0]};
            if (t == CALL) begin
                m_tos = (m_tos + 1) % 8;
                m_stack[m_tos] = ra;
                if (m_count < 8) m_count = m_count + 1;
                e_pc = ja; e_hit = 1'b1;
            end else if (t == RET) begin
                if (m_count > 0) begin
                    e_pc = m_stack[m_tos]; e_hit = 1'b1;
                    m_tos = (m_tos + 7) % 8;
                    m_count = m_count - 1;
                end else begin
                    e_pc = pc + 32'd4; e_hit = 1'b0;
                end
            end else if (t == JALR) begin
                idx = int'(pc[4:2]);
                if (m_bv[idx] && m_btag[idx] == pc[12:5]) begin
                    e_pc = m_btgt[idx]; e_hit = 1'b1;
                end else begin
                    e_pc = pc + 32'd4; e_hit = 1'b0;
                end
            end else begin
                e_pc = ja; e_hit = 1'b1;
            end
        end else begin
            e_v = 1'b0;
        end
        if (uv) begin
            idx = int'(upc[4:2]);
            m_bv[idx] = 1'b1; m_btag[idx] = upc[12:5]; m_btgt[idx] = ut;
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic req(input logic [2:0] t, input logic [31:0] pc,
                       input logic [31:0] ja, input logic [31:0] ra);
        step(1'b1, t, pc, ja, ra, 1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        model_reset();
        #3;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_nextPc !== 32'h0 || bus.o_hit !== 1'b0 || bus.o_chkpt !== 7'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b pc=%h hit=%0b chk=%h, want all zero",
                     bus.o_valid, bus.o_nextPc, bus.o_hit, bus.o_chkpt);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        req(RET, 32'h100, 32'h0, 32'h0);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_nextPc !== 32'h104 || bus.o_hit !== 1'b0 || bus.o_chkpt !== 7'h0) begin
            errors++;
            $display("FAIL reset_ret_fallback: got v=%0b pc=%h hit=%0b chk=%h, want v=1 pc=104 hit=0 chk=0",
                     bus.o_valid, bus.o_nextPc, bus.o_hit, bus.o_chkpt);
        end
        step(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_pulse: got o_valid=%0b, want 0", bus.o_valid);
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        req(CALL, 32'h200, 32'h800, 32'h204);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_nextPc !== 32'h800 || bus.o_hit !== 1'b1 || bus.o_chkpt !== 7'h00) begin
            errors++;
            $display("FAIL call_target: got v=%0b pc=%h hit=%0b chk=%h, want v=1 pc=800 hit=1 chk=00",
                     bus.o_valid, bus.o_nextPc, bus.o_hit, bus.o_chkpt);
        end
        req(RET, 32'h800, 32'h0, 32'h0);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_nextPc !== 32'h204 || bus.o_hit !== 1'b1 || bus.o_chkpt !== 7'h11) begin
            errors++;
            $display("FAIL call_then_ret: got v=%0b pc=%h hit=%0b chk=%h, want v=1 pc=204 hit=1 chk=11",
                     bus.o_valid, bus.o_nextPc, bus.o_hit, bus.o_chkpt);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] want_pc;
        logic        want_hit;
        do_reset();
        for (int i = 1; i <= 9; i++) req(CALL, 32'h1000, 32'h2000, 32'(i * 16));
        for (int k = 0; k < 9; k++) begin
            req(RET, 32'h3000, 32'h0, 32'h0);
            want_pc  = (k < 8) ? 32'(32'h90 - k * 16) : 32'h3004;
            want_hit = (k < 8);
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_nextPc !== want_pc || bus.o_hit !== want_hit) begin
                errors++;
                $display("FAIL overflow_ret%0d: got v=%0b pc=%h hit=%0b, want v=1 pc=%h hit=%0b",
                         k, bus.o_valid, bus.o_nextPc, bus.o_hit, want_pc, want_hit);
            end
        end
    endtask

    task automatic test_jalr();
        logic [31:0] pcs  [5];
        logic [31:0] want [5];
        logic        wh   [5];
        pcs[0] = 32'h40; want[0] = 32'h44;   wh[0] = 1'b0;
        pcs[1] = 32'h40; want[1] = 32'h1000; wh[1] = 1'b1;
        pcs[2] = 32'h60; want[2] = 32'h64;   wh[2] = 1'b0;
        pcs[3] = 32'h80; want[3] = 32'h84;   wh[3] = 1'b0;
        pcs[4] = 32'h80; want[4] = 32'h2000; wh[4] = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) step(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 7'h0, 1'b1, 32'h40, 32'h1000);
            if (i == 3) step(1'b1, JALR, pcs[i], 32'h7777, 32'h0, 1'b0, 32'h0, 7'h0, 1'b1, 32'h80, 32'h2000);
            else        req(JALR, pcs[i], 32'h7777, 32'h0);
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_nextPc !== want[i] || bus.o_hit !== wh[i]) begin
                errors++;
                $display("FAIL jalr_%0d: got v=%0b pc=%h hit=%0b, want v=1 pc=%h hit=%0b",
                         i, bus.o_valid, bus.o_nextPc, bus.o_hit, want[i], wh[i]);
            end
        end
        req(JAL, 32'h90, 32'h5550, 32'h0);
        checks++;
        if (bus.o_nextPc !== 32'h5550 || bus.o_hit !== 1'b1) begin
            errors++;
            $display("FAIL direct_jal: got pc=%h hit=%0b, want pc=5550 hit=1", bus.o_nextPc, bus.o_hit);
        end
    endtask

    task automatic test_redirect();
        logic [6:0] c;
        do_reset();
        req(CALL, 32'h100, 32'h500, 32'hAAA0);
        req(CALL, 32'h500, 32'h600, 32'hB000);
        c = bus.o_chkpt;
        checks++;
        if (c !== 7'h11) begin
            errors++;
            $display("FAIL redirect_capture: got chk=%h, want 11", c);
        end
        req(CALL, 32'h600, 32'h700, 32'hC000);
        req(CALL, 32'h700, 32'h800, 32'hD000);
        step(1'b1, CALL, 32'h800, 32'h900, 32'hE000, 1'b1, 32'h3000, c, 1'b0, 32'h0, 32'h0);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_nextPc !== 32'h3000 || bus.o_hit !== 1'b1) begin
            errors++;
            $display("FAIL redirect_out: got v=%0b pc=%h hit=%0b, want v=1 pc=3000 hit=1",
                     bus.o_valid, bus.o_nextPc, bus.o_hit);
        end
        req(RET, 32'h3000, 32'h0, 32'h0);
        checks++;
        if (bus.o_nextPc !== 32'hAAA0 || bus.o_hit !== 1'b1 || bus.o_chkpt !== 7'h11) begin
            errors++;
            $display("FAIL redirect_ret: got pc=%h hit=%0b chk=%h, want pc=aaa0 hit=1 chk=11",
                     bus.o_nextPc, bus.o_hit, bus.o_chkpt);
        end
        req(RET, 32'hAAA0, 32'h0, 32'h0);
        checks++;
        if (bus.o_nextPc !== 32'hAAA4 || bus.o_hit !== 1'b0) begin
            errors++;
            $display("FAIL redirect_no_push: got pc=%h hit=%0b, want pc=aaa4 hit=0", bus.o_nextPc, bus.o_hit);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req(CALL, 32'h100, 32'h900, 32'h104);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_nextPc !== 32'h0 || bus.o_hit !== 1'b0 || bus.o_chkpt !== 7'h0) begin
            errors++;
            $display("FAIL midreset_clear: got v=%0b pc=%h hit=%0b chk=%h, want all zero",
                     bus.o_valid, bus.o_nextPc, bus.o_hit, bus.o_chkpt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        req(RET, 32'h300, 32'h0, 32'h0);
        checks++;
        if (bus.o_nextPc !== 32'h304 || bus.o_hit !== 1'b0 || bus.o_chkpt !== 7'h0) begin
            errors++;
            $display("FAIL midreset_ret: got pc=%h hit=%0b chk=%h, want pc=304 hit=0 chk=0",
                     bus.o_nextPc, bus.o_hit, bus.o_chkpt);
        end
    endtask

    task automatic test_random();
        logic        v, rd, uv;
        logic [2:0]  t;
        logic [31:0] pc, upc;
        logic [6:0]  rchk;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            v    = ($urandom_range(0, 9) != 0);
            t    = 3'($urandom_range(0, 7));
            pc   = 32'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2));
            upc  = 32'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2));
            rd   = ($urandom_range(0, 11) == 0);
            uv   = ($urandom_range(0, 3) == 0);
            rchk = {3'($urandom_range(0, 7)), 4'($urandom_range(0, 8))};
            step(v, t, pc, $urandom, $urandom, rd, $urandom, rchk, uv, upc, $urandom);
            checks++;
            if (bus.o_valid !== e_v || (e_v && (bus.o_nextPc !== e_pc || bus.o_hit !== e_hit ||
                                               (!e_rd && bus.o_chkpt !== e_chk)))) begin
                errors++;
                $display("FAIL random_%0d: got v=%0b pc=%h hit=%0b chk=%h, want v=%0b pc=%h hit=%0b chk=%h",
                         n, bus.o_valid, bus.o_nextPc, bus.o_hit, bus.o_chkpt, e_v, e_pc, e_hit, e_chk);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_call_ret();
        test_overflow();
        test_jalr();
        test_redirect();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jump_target_predictor.md
# jump_target_predictor

Parametrised next-PC predictor for the instruction-fetch stage. For the first taken jump in a fetch block, it resolves the target from four sources:
- a circular return-address stack (RAS) for CALL/RET;
- a tagged indirect-target BTB for JALR;
- the decoded direct address for other jumps;
- a backend redirect, which overrides everything.

It adds clocked operation, stack checkpoint/restore on mispredict, tagged BTB hits, and an empty-stack fallback.

## Interface
Parameters:
- XLEN, 32, address width
- RAS_DEPTH, 8, stack entries (power of two, ≥2)
- BTB_ENTRIES, 8, indirect table entries (power of two)
- TAG_BITS, 8, BTB tag width
- CHK_W, 2*$clog2(RAS_DEPTH)+1, checkpoint width {tos, count}

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- i_valid  in  1  prediction request this cycle
- i_type  in  3  jump type (package encodings)
- i_pc  in  XLEN  PC of the jump instruction
- i_jaddr  in  XLEN  decoded direct target
- i_retAddr  in  XLEN  fall-through address pushed on CALL
- o_valid  out  1  prediction available
- o_nextPc  out  XLEN  predicted next fetch PC
- o_hit  out  1  1 = real prediction, 0 = fallback used
- o_chkpt  out  CHK_W  RAS state before this request's push/pop
- i_redirect  in  1  backend mispredict
- i_redirectPc  in  XLEN  correct PC
- i_redirectChkpt  in  CHK_W  checkpoint to restore
- i_updValid  in  1  BTB training write
- i_updPc  in  XLEN  PC of resolved JALR
- i_updTarget  in  XLEN  resolved target

## Operation
- Request handling when i_valid=1 and i_redirect=0, by i_type:
  - CALL: push i_retAddr; nextPc = i_jaddr; hit = 1.
  - RET, count>0: nextPc = stack[tos]; pop; hit = 1.
  - RET, count=0: nextPc = i_pc+4; hit = 0; stack unchanged.
  - JALR: idx = i_pc[2 +: log2(BTB_ENTRIES)]; tag = i_pc[2+log2(BTB_ENTRIES) +: TAG_BITS].
    - Valid entry with matching tag: nextPc = target, hit = 1.
    - Otherwise: nextPc = i_pc+4, hit = 0.
  - Any other type: nextPc = i_jaddr; hit = 1.
- Stack pointer and count:
  - Push: tos = tos+1 mod RAS_DEPTH, then write. count saturates at RAS_DEPTH; a push while full overwrites the oldest entry.
  - Pop: tos = tos-1 mod RAS_DEPTH; count-1.
- Redirect:
  - Takes priority over the same-cycle request, which is dropped.
  - tos and count are loaded from i_redirectChkpt. Entry contents are not restored.
  - Next cycle: o_valid=1, o_nextPc = i_redirectPc, o_hit=1.
- BTB update:
  - When i_updValid=1, entry[idx(i_updPc)] gets {valid=1, tag(i_updPc), i_updTarget}.
  - This is independent of redirect.
- Reset: o_valid/o_nextPc/o_hit/o_chkpt = 0; tos = 0, count = 0; all BTB valid bits = 0. Stack and BTB data are don't-care.

## Timing
- Latency is 1 cycle: a request at edge N produces o_valid at edge N+1. All outputs are registered.
- o_valid is a single-cycle pulse per accepted request or redirect. There is no backpressure; one request per cycle.
- Back-to-back CALL then RET on consecutive cycles must return the just-pushed address. The stack state is updated at the edge.
- A BTB write and a lookup to the same idx in the same cycle: the lookup sees the old entry.
- Reset asserted mid-operation clears state immediately. The first request after deassertion sees an empty stack.

## Structure
- Package jtp_pkg:
  - type encodings JAL=3'd1, BR=3'd2, JALR=3'd3, CALL=3'd4, RET=3'd5;
  - checkpoint struct {tos, count}.
- Sub-module jtp_ras: circular stack, tos/count, push/pop/restore, checkpoint output.
- The BTB and output mux live in the top.

## Test plan
- Reset, then RET at i_pc=0x100 → o_nextPc=0x104, o_hit=0, o_chkpt=0.
- CALL (retAddr=0x204, jaddr=0x800) then RET next cycle → second output o_nextPc=0x204, hit=1.
- RAS_DEPTH=8: 9 CALLs with retAddr 0x10..0x90, then 9 RETs:
  - first 8 RETs return 0x90 down to 0x20;
  - 9th RET falls back (hit=0).
- JALR at 0x40 with empty BTB → 0x44, hit=0; update {0x40→0x1000}; repeat → 0x1000, hit=1; JALR at aliasing PC with different tag → miss.
- CALL captures o_chkpt=C, followed by 2 more CALLs; then redirect(0x3000, C) with a simultaneous CALL request:
  - output 0x3000, hit=1;
  - the dropped CALL does not push;
  - the next RET returns the entry at C's tos.
- Assert rst between a CALL and a RET → RET after reset falls back (hit=0).
